// File: rtl/muldiv_unit_if.sv
// Requester/register-file side bundle for muldiv_unit: operands and start in, write-back strobe and status out.
// The requester drives the master modport; the unit binds to the slave modport.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH         = 8,
    parameter int REGISTER_ADDR_BITS = 2
);
    logic                          start;
    logic                          op;
    logic [DATA_WIDTH-1:0]         a_operand;
    logic [DATA_WIDTH-1:0]         b_operand;
    logic [REGISTER_ADDR_BITS-1:0] dest_in;
    logic                          busy;
    logic                          done;
    logic                          wb_enable;
    logic [DATA_WIDTH-1:0]         wb_data;
    logic [REGISTER_ADDR_BITS-1:0] wb_dest;
    logic [DATA_WIDTH-1:0]         hi;
    logic                          div_by_zero;

    modport master (
        output start, op, a_operand, b_operand, dest_in,
        input  busy, done, wb_enable, wb_data, wb_dest, hi, div_by_zero
    );

    modport slave (
        input  start, op, a_operand, b_operand, dest_in,
        output busy, done, wb_enable, wb_data, wb_dest, hi, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned shift-add multiply / restoring divide; write-back DATA_WIDTH+1 cycles after accept (1 for divide by zero).
// No backpressure: start is only sampled in IDLE and requests arriving while busy are dropped, not queued.
module muldiv_unit #(
    parameter int DATA_WIDTH         = 8,
    parameter int REGISTER_ADDR_BITS = 2
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_unit_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t                        state_q;
    logic                          op_q;
    logic [CW-1:0]                 cnt_q;
    logic [2*W-1:0]                acc_q;
    logic [W-1:0]                  a_q;
    logic [W-1:0]                  b_q;
    logic [REGISTER_ADDR_BITS-1:0] dest_q;
    logic                          busy_q;
    logic                          done_q;
    logic [W-1:0]                  wb_data_q;
    logic [REGISTER_ADDR_BITS-1:0] wb_dest_q;
    logic [W-1:0]                  hi_q;
    logic                          dbz_q;

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_acc_d;
    logic [W:0]     div_sh;
    logic [W:0]     div_trial;
    logic [2*W-1:0] div_acc_d;
    logic [2*W-1:0] acc_d;

    // Multiply keeps the partial product in the upper half and shifts finished
    // bits into the lower half; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (b_q[0] ? a_q : {W{1'b0}})};
        mul_acc_d = {mul_sum, acc_q[W-1:1]};
        div_sh    = {acc_q[2*W-1:W], acc_q[W-1]};
        div_trial = div_sh - {1'b0, b_q};
        if (!div_trial[W]) begin
            div_acc_d = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            div_acc_d = {div_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end
        acc_d = op_q ? div_acc_d : mul_acc_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dest_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wb_data_q <= '0;
            wb_dest_q <= '0;
            hi_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.a_operand;
                        b_q    <= bus.b_operand;
                        dest_q <= bus.dest_in;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (bus.op && (bus.b_operand == '0)) begin
                            state_q   <= WB;
                            acc_q     <= '0;
                            done_q    <= 1'b1;
                            wb_data_q <= '1;
                            wb_dest_q <= bus.dest_in;
                            hi_q      <= bus.a_operand;
                            dbz_q     <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            acc_q   <= bus.op ? {{W{1'b0}}, bus.a_operand} : '0;
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (!op_q) begin
                        b_q <= b_q >> 1;
                    end
                    if (cnt_q == CW'(W - 1)) begin
                        state_q   <= WB;
                        cnt_q     <= '0;
                        done_q    <= 1'b1;
                        wb_data_q <= acc_d[W-1:0];
                        wb_dest_q <= dest_q;
                        hi_q      <= acc_d[2*W-1:W];
                    end
                end
                WB: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    wb_data_q <= '0;
                    wb_dest_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.wb_enable   = done_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_dest     = wb_dest_q;
    assign bus.hi          = hi_q;
    assign bus.div_by_zero = dbz_q;
endmodule
